// File: rtl/code_seq_gen.sv
// 3-bit select-code sequencer for the one-hot decoder: prescaled stepping with
// up/down wrap counting, ping-pong sweep, pause and synchronous preload.
//
// state  | meaning
// S_UP   | ping-pong sweep is ascending toward 7
// S_DOWN | ping-pong sweep is descending toward 0
module code_seq_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       en,
  input  logic       dir,
  input  logic       mode,
  input  logic       load,
  input  logic [2:0] load_val,
  output logic       out1,
  output logic       out2,
  output logic       out3,
  output logic       step_pulse,
  output logic       wrap_flag
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] PRE_MAX = CW'(TICK_DIV - 1);

  typedef enum logic {
    S_UP   = 1'b0,
    S_DOWN = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      code_q, code_d;
  logic [CW-1:0]   pre_q, pre_d;
  logic            step_q, step_d;
  logic            wrap_q, wrap_d;
  logic            tick;

  // Load outranks the tick, so a tick only counts when no preload is pending.
  assign tick = en && !load && (pre_q == PRE_MAX);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= S_UP;
      code_q  <= 3'b000;
      pre_q   <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      pre_q   <= pre_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    pre_d   = pre_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;

    if (load) begin
      code_d = load_val;
      pre_d  = '0;
      if (load_val == 3'd0) begin
        state_d = S_UP;
      end else if (load_val == 3'd7) begin
        state_d = S_DOWN;
      end
    end else if (tick) begin
      pre_d  = '0;
      step_d = 1'b1;
      if (!mode) begin
        // Wrap mode leaves the sweep direction untouched.
        if (!dir) begin
          code_d = code_q + 3'd1;
          wrap_d = (code_q == 3'd7);
        end else begin
          code_d = code_q - 3'd1;
          wrap_d = (code_q == 3'd0);
        end
      end else begin
        unique case (state_q)
          S_UP: begin
            if (code_q == 3'd7) begin
              code_d  = 3'd6;
              state_d = S_DOWN;
              wrap_d  = 1'b1;
            end else begin
              code_d = code_q + 3'd1;
            end
          end
          S_DOWN: begin
            if (code_q == 3'd0) begin
              code_d  = 3'd1;
              state_d = S_UP;
              wrap_d  = 1'b1;
            end else begin
              code_d = code_q - 3'd1;
            end
          end
          default: begin
            state_d = S_UP;
          end
        endcase
      end
    end else if (en) begin
      pre_d = pre_q + CW'(1);
    end
  end

  assign out1       = code_q[2];
  assign out2       = code_q[1];
  assign out3       = code_q[0];
  assign step_pulse = step_q;
  assign wrap_flag  = wrap_q;

endmodule
